// File: rtl/esc_decoder.sv
// Escape-mode trio-line decoder: synchronizes A/B/C, glitch-filters the line class,
// recovers one bit per mark and assembles LSB-first bytes with framing/error pulses.
module esc_decoder #(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned GlitchCycles = 2,
    parameter int unsigned SpaceTimeout = 64
) (
    input  logic       TxClkEsc,
    input  logic       RstN,
    input  logic       DecoderEn,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       ErrEsc,
    output logic       ErrSync,
    output logic       FrameEnd,
    output logic       Busy
);
    localparam int unsigned RunW = 4;
    localparam int unsigned ToW  = 8;
    localparam int unsigned BitW = 3;

    localparam logic [RunW-1:0] RunMax  = RunW'(GlitchCycles);
    localparam logic [ToW-1:0]  ToMax   = ToW'(SpaceTimeout);
    localparam logic [BitW-1:0] LastBit = BitW'(7);

    typedef enum logic [1:0] {
        ClsSpace   = 2'd0,
        ClsMark0   = 2'd1,
        ClsMark1   = 2'd2,
        ClsIllegal = 2'd3
    } lineClass_t;

    typedef enum logic [1:0] {
        StDisabled  = 2'd0,
        StWaitSpace = 2'd1,
        StSpace     = 2'd2,
        StMark      = 2'd3
    } state_t;

    logic [SyncStages-1:0] syncA;
    logic [SyncStages-1:0] syncB;
    logic [SyncStages-1:0] syncC;

    lineClass_t      lineCls;
    lineClass_t      prevCls;
    logic [RunW-1:0] runCnt;
    logic [RunW-1:0] runNext;
    logic            sameRun;
    logic            accepted;

    logic [ToW-1:0]  toCnt;
    logic            toHit;

    state_t          state;
    logic [BitW-1:0] bitCnt;
    logic [7:0]      shreg;
    logic [7:0]      shiftByte;
    logic            markBit;
    logic            isMark;
    logic            oppositeMark;

    // Multi-flop synchronizers on the asynchronous pad lines
    always_ff @(posedge TxClkEsc or negedge RstN) begin
        if (!RstN) begin
            syncA <= '0;
            syncB <= '0;
            syncC <= '0;
        end else begin
            syncA <= {syncA[SyncStages-2:0], A};
            syncB <= {syncB[SyncStages-2:0], B};
            syncC <= {syncC[SyncStages-2:0], C};
        end
    end

    always_comb begin
        lineCls = ClsIllegal;
        case ({syncA[SyncStages-1], syncB[SyncStages-1], syncC[SyncStages-1]})
            3'b000:  lineCls = ClsSpace;
            3'b100:  lineCls = ClsMark1;
            3'b001:  lineCls = ClsMark0;
            default: lineCls = ClsIllegal;
        endcase
    end

    // Run-length glitch filter: accept exactly once, when a run reaches GlitchCycles
    always_comb begin
        sameRun = (lineCls == prevCls);
        runNext = RunW'(1);
        if (sameRun) begin
            if (runCnt >= RunMax) begin
                runNext = RunMax;
            end else begin
                runNext = runCnt + RunW'(1);
            end
        end
        accepted = (runNext == RunMax) && !(sameRun && (runCnt == RunMax));

        markBit      = (lineCls == ClsMark1);
        isMark       = (lineCls == ClsMark0) || (lineCls == ClsMark1);
        oppositeMark = isMark && (markBit != shreg[7]);
        shiftByte    = {markBit, shreg[7:1]};
        toHit        = (state == StSpace) && (lineCls == ClsSpace) &&
                       (toCnt == ToMax - ToW'(1));
    end

    // Decoder FSM with registered status pulses; shreg[7] holds the current mark's bit
    always_ff @(posedge TxClkEsc or negedge RstN) begin
        if (!RstN) begin
            state    <= StDisabled;
            prevCls  <= ClsSpace;
            runCnt   <= '0;
            toCnt    <= '0;
            bitCnt   <= '0;
            shreg    <= '0;
            RxData   <= '0;
            RxValid  <= 1'b0;
            ErrEsc   <= 1'b0;
            ErrSync  <= 1'b0;
            FrameEnd <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            RxValid  <= 1'b0;
            ErrEsc   <= 1'b0;
            ErrSync  <= 1'b0;
            FrameEnd <= 1'b0;
            prevCls  <= lineCls;

            if (!DecoderEn) begin
                state  <= StDisabled;
                runCnt <= '0;
                toCnt  <= '0;
                bitCnt <= '0;
                shreg  <= '0;
                Busy   <= 1'b0;
            end else begin
                runCnt <= (state == StDisabled) ? '0 : runNext;
                toCnt  <= '0;

                case (state)
                    StDisabled: begin
                        state <= StWaitSpace;
                        Busy  <= 1'b0;
                    end

                    StWaitSpace: begin
                        Busy <= 1'b0;
                        if (accepted && (lineCls == ClsSpace)) begin
                            state <= StSpace;
                        end
                    end

                    StSpace: begin
                        if (lineCls != ClsSpace) begin
                            toCnt <= '0;
                        end else if (toCnt != ToMax) begin
                            toCnt <= toCnt + ToW'(1);
                        end

                        if (accepted && isMark) begin
                            shreg <= shiftByte;
                            state <= StMark;
                            Busy  <= 1'b1;
                            if (bitCnt == LastBit) begin
                                RxData  <= shiftByte;
                                RxValid <= 1'b1;
                                bitCnt  <= '0;
                            end else begin
                                bitCnt <= bitCnt + BitW'(1);
                            end
                        end else if (accepted && (lineCls == ClsIllegal)) begin
                            ErrEsc <= 1'b1;
                            bitCnt <= '0;
                            state  <= StWaitSpace;
                            Busy   <= 1'b0;
                        end else if (toHit) begin
                            FrameEnd <= 1'b1;
                            ErrSync  <= (bitCnt != '0);
                            bitCnt   <= '0;
                            Busy     <= 1'b0;
                        end
                    end

                    StMark: begin
                        if (accepted) begin
                            if (lineCls == ClsSpace) begin
                                state <= StSpace;
                                Busy  <= (bitCnt != '0);
                            end else if ((lineCls == ClsIllegal) || oppositeMark) begin
                                ErrEsc <= 1'b1;
                                bitCnt <= '0;
                                state  <= StWaitSpace;
                                Busy   <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state <= StDisabled;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
